// File: rtl/vga_timing_gen_if.sv
// VGA timing generator bus: the coordinate/colour exchange with the compositor
// and the registered pin-side outputs toward the DAC/HDMI encoder.
// The generator side uses the master modport. The compositor/encoder side uses the slave modport.
interface vga_timing_gen_if;
  logic [11:0] vga_x;
  logic [11:0] vga_y;
  logic [23:0] vga_rgb;
  logic        test_en;
  logic        out_hs;
  logic        out_vs;
  logic        out_de;
  logic [23:0] out_rgb;
  logic        frame_start;

  modport master (
    output vga_x, vga_y, out_hs, out_vs, out_de, out_rgb, frame_start,
    input  vga_rgb, test_en
  );

  modport slave (
    input  vga_x, vga_y, out_hs, out_vs, out_de, out_rgb, frame_start,
    output vga_rgb, test_en
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator and output aligner for the VGA path.
// Issues active-area coordinates to the compositor. Delays sync/enable/frame-start
// by PIPE cycles so they line up with the returned colour, and registers all pins.
// Optional colour-bar test pattern: define VGA_TEST_PATTERN_EN and drive test_en=1.
// PIPE must be 1..4, H_ACTIVE must be >= 8, and the totals must not exceed 4095.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int PIPE     = 2
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master bus
);

  localparam logic [11:0] C_H_TOTAL   = 12'(H_SYNC + H_BP + H_ACTIVE + H_FP);
  localparam logic [11:0] C_V_TOTAL   = 12'(V_SYNC + V_BP + V_ACTIVE + V_FP);
  localparam logic [11:0] C_H_SYNC    = 12'(H_SYNC);
  localparam logic [11:0] C_V_SYNC    = 12'(V_SYNC);
  localparam logic [11:0] C_H_ACT_BEG = 12'(H_SYNC + H_BP);
  localparam logic [11:0] C_H_ACT_END = 12'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [11:0] C_V_ACT_BEG = 12'(V_SYNC + V_BP);
  localparam logic [11:0] C_V_ACT_END = 12'(V_SYNC + V_BP + V_ACTIVE);

  // Stage word layout: {[bar index,] hs, vs, de, fs}
`ifdef VGA_TEST_PATTERN_EN
  localparam int ST_W = 7;
  localparam logic [11:0] C_BAR_W = 12'(H_ACTIVE / 8);
`else
  localparam int ST_W = 4;
`endif

  logic [11:0] r_h_cnt;
  logic [11:0] r_v_cnt;
  logic        w_h_last;
  logic        w_v_last;
  logic        w_hs0;
  logic        w_vs0;
  logic        w_h_act;
  logic        w_v_act;
  logic        w_de0;
  logic        w_fs0;
  logic [11:0] w_x_act;
  logic [11:0] w_y_act;
  logic [ST_W-1:0] w_st0;
  logic [PIPE-1:0][ST_W-1:0] w_chain;
  logic [ST_W-1:0] w_tap;
  logic [23:0] w_rgb_next;

  logic        r_out_hs;
  logic        r_out_vs;
  logic        r_out_de;
  logic        r_frame_start;
  logic [23:0] r_out_rgb;

  assign w_h_last = (r_h_cnt == (C_H_TOTAL - 12'd1));
  assign w_v_last = (r_v_cnt == (C_V_TOTAL - 12'd1));

  // Raster counters: h wraps every line, v advances (and wraps) on the h wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_cnt <= 12'd0;
      r_v_cnt <= 12'd0;
    end else if (w_h_last) begin
      r_h_cnt <= 12'd0;
      if (w_v_last) begin
        r_v_cnt <= 12'd0;
      end else begin
        r_v_cnt <= r_v_cnt + 12'd1;
      end
    end else begin
      r_h_cnt <= r_h_cnt + 12'd1;
    end
  end

  assign w_hs0   = (r_h_cnt < C_H_SYNC);
  assign w_vs0   = (r_v_cnt < C_V_SYNC);
  assign w_h_act = (r_h_cnt >= C_H_ACT_BEG) && (r_h_cnt < C_H_ACT_END);
  assign w_v_act = (r_v_cnt >= C_V_ACT_BEG) && (r_v_cnt < C_V_ACT_END);
  assign w_de0   = w_h_act && w_v_act;
  assign w_fs0   = w_de0 && (r_h_cnt == C_H_ACT_BEG) && (r_v_cnt == C_V_ACT_BEG);
  assign w_x_act = r_h_cnt - C_H_ACT_BEG;
  assign w_y_act = r_v_cnt - C_V_ACT_BEG;

  // All-ones outside the active area so no compositor window can match it
  assign bus.vga_x = w_de0 ? w_x_act : 12'hFFF;
  assign bus.vga_y = w_de0 ? w_y_act : 12'hFFF;

`ifdef VGA_TEST_PATTERN_EN
  logic [11:0] w_bar_full;
  logic [2:0]  w_bar0;

  // Fixed bar colours: white, yellow, cyan, green, magenta, red, blue, black
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  assign w_bar_full = w_x_act / C_BAR_W;
  // Columns past 8*bar width (H_ACTIVE not a multiple of 8) stay in the last bar
  assign w_bar0 = !w_de0 ? 3'd0 : ((w_bar_full > 12'd7) ? 3'd7 : w_bar_full[2:0]);
  assign w_st0  = {w_bar0, w_hs0, w_vs0, w_de0, w_fs0};
`else
  logic w_unused_test_en;
  assign w_unused_test_en = bus.test_en;
  assign w_st0 = {w_hs0, w_vs0, w_de0, w_fs0};
`endif

  // Stage 0 is combinational; stages 1..PIPE-1 are registers, and the output
  // register below is stage PIPE, so coordinate-to-pin latency is PIPE.
  assign w_chain[0] = w_st0;

  for (genvar g = 1; g < PIPE; g++) begin : g_stage
    logic [ST_W-1:0] r_stage;

    // One pipeline stage of the delayed sync/enable/frame-start word
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_stage <= {ST_W{1'b0}};
      end else begin
        r_stage <= w_chain[g-1];
      end
    end

    assign w_chain[g] = r_stage;
  end

  assign w_tap = w_chain[PIPE-1];

  // Colour selection at stage PIPE-1: compositor data (or bars), blanked outside de
  always_comb begin
    w_rgb_next = 24'h0;
    if (w_tap[1]) begin
`ifdef VGA_TEST_PATTERN_EN
      if (bus.test_en) begin
        w_rgb_next = bar_colour(w_tap[6:4]);
      end else begin
        w_rgb_next = bus.vga_rgb;
      end
`else
      w_rgb_next = bus.vga_rgb;
`endif
    end else begin
      w_rgb_next = 24'h0;
    end
  end

  // Registered pin stage with polarity applied to the syncs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_hs      <= ~SYNC_POL;
      r_out_vs      <= ~SYNC_POL;
      r_out_de      <= 1'b0;
      r_frame_start <= 1'b0;
      r_out_rgb     <= 24'h0;
    end else begin
      r_out_hs      <= w_tap[3] ? SYNC_POL : ~SYNC_POL;
      r_out_vs      <= w_tap[2] ? SYNC_POL : ~SYNC_POL;
      r_out_de      <= w_tap[1];
      r_frame_start <= w_tap[0];
      r_out_rgb     <= w_rgb_next;
    end
  end

  assign bus.out_hs      = r_out_hs;
  assign bus.out_vs      = r_out_vs;
  assign bus.out_de      = r_out_de;
  assign bus.frame_start = r_frame_start;
  assign bus.out_rgb     = r_out_rgb;

endmodule
